// File: rtl/redirect_ctrl_pkg.sv
// redirect_ctrl_pkg: shared source indices, flush boundary bits and state codes for the redirect controller.
// Optional REDIRECT_CNT_EN (see redirect_ctrl) adds a completed-redirect counter.
package redirect_ctrl_pkg;
   localparam int NSRC = 6;
   localparam logic [2:0] SRC_WB  = 3'd0;
   localparam logic [2:0] SRC_EX2 = 3'd1;
   localparam logic [2:0] SRC_EX1 = 3'd2;
   localparam logic [2:0] SRC_REG = 3'd3;
   localparam logic [2:0] SRC_ID  = 3'd4;
   localparam logic [2:0] SRC_IF1 = 3'd5;
   localparam int FB_EX2_WB  = 0;
   localparam int FB_EX1_EX2 = 1;
   localparam int FB_REG_EX1 = 2;
   localparam int FB_ID_REG  = 3;
   localparam int FB_FIFO_ID = 4;
   localparam int FB_FRONT   = 5;
   localparam logic IDLE = 1'b0;
   localparam logic PEND = 1'b1;
   // Boundaries at or younger than the winning source get flushed.
   function automatic logic [NSRC-1:0] therm_from(input logic [2:0] idx);
      logic [NSRC-1:0] t;
      for (int b = 0; b < NSRC; b++) t[b] = 3'(b) >= idx;
      return t;
   endfunction
endpackage

// File: rtl/redirect_prio_enc.sv
// redirect_prio_enc: lowest-set-bit (oldest source) priority encoder with thermometer flush mask.
module redirect_prio_enc
   import redirect_ctrl_pkg::*;
(
   input  logic [NSRC-1:0] req,
   output logic            any,
   output logic [2:0]      idx,
   output logic [NSRC-1:0] therm
);
   always_comb begin
      idx = '0;
      for (int i = NSRC - 1; i >= 0; i--) if (req[i]) idx = 3'(i);
   end
   assign any   = |req;
   assign therm = any ? therm_from(idx) : '0;
endmodule

// File: rtl/redirect_ctrl.sv
// redirect_ctrl: picks the oldest flush-with-redirect request, drives the flush mask and holds the target PC for IF0.
// Define REDIRECT_CNT_EN to add the redir_cnt completed-handshake counter.
module redirect_ctrl
   import redirect_ctrl_pkg::*;
#(
   parameter int PC_W = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NSRC-1:0]    req,
   input  logic [NSRC*PC_W-1:0] req_pc,
   input  logic               if0_ready,
   output logic               redir_valid,
   output logic [PC_W-1:0]    redir_pc,
   output logic [2:0]         redir_src,
   output logic [NSRC-1:0]    flush_mask
`ifdef REDIRECT_CNT_EN
   ,
   output logic [31:0]        redir_cnt
`endif
);
   logic            state_q;
   logic [2:0]      src_q;
   logic [PC_W-1:0] pc_q;
   logic            any;
   logic [2:0]      w;
   logic [NSRC-1:0] therm;
   logic [PC_W-1:0] sel_pc;
   logic            accept;
   redirect_prio_enc u_enc (.req(req), .any(any), .idx(w), .therm(therm));
   always_comb begin
      sel_pc = '0;
      for (int s = 0; s < NSRC; s++) if (w == 3'(s)) sel_pc = req_pc[s*PC_W +: PC_W];
   end
   // Equal or younger requests while pending are already covered by the pending flush.
   assign accept     = any && (state_q == IDLE || w < src_q);
   assign flush_mask = accept ? therm : '0;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         src_q   <= '0;
         pc_q    <= '0;
      end else if (accept) begin
         state_q <= PEND;
         src_q   <= w;
         pc_q    <= sel_pc;
      end else if (state_q == PEND && if0_ready) begin
         state_q <= IDLE;
      end
   end
   assign redir_valid = state_q == PEND;
   assign redir_pc    = redir_valid ? pc_q : '0;
   assign redir_src   = redir_valid ? src_q : '0;
`ifdef REDIRECT_CNT_EN
   logic [31:0] cnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else if (redir_valid && if0_ready) cnt_q <= cnt_q + 32'd1;
   end
   assign redir_cnt = cnt_q;
`endif
endmodule
